ilog2_arb: RTL and testbench

ILOG2_ARB -- requirements
Module: ilog2_arb

---
 rtl/ilog2_arb.sv | 192 +++++++++++++++++++
 tb/tb_ilog2_arb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ilog2_arb.sv
// ilog2_arb: round-robin front end that lets NREQ requesters share one
// pipelined floor(log2) core. Each requester holds two result credits, so its
// two-entry result FIFO can never overflow and a stalled consumer only blocks
// its own requester. Zero operands bypass the core via a flag in the tag pipe.
module ilog2_arb #(
  parameter int NREQ = 4,
  parameter int LAT  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [32*NREQ-1:0]  req_v,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [5*NREQ-1:0]   rsp_log2,
  output logic [NREQ-1:0]     rsp_zero,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [31:0]         core_v,
  input  logic [4:0]          core_log2,
  output logic                busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_ptr;
  logic [1:0]      inflight [NREQ];
  logic [1:0]      fifo_cnt [NREQ];
  logic [1:0]      credit   [NREQ];
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] gnt_vec;
  logic [NREQ-1:0] push_vec;
  logic [NREQ-1:0] pop_vec;
  logic [NREQ-1:0] fifo_ne;

  logic            gnt_any;
  logic [PW-1:0]   gnt_id;
  logic [31:0]     gnt_opnd;
  logic            gnt_zero;

  // Issue stage sits alongside core_v: it is the cycle the core samples.
  logic            iss_valid;
  logic [PW-1:0]   iss_id;
  logic            iss_zero;

  logic            tp_valid [LAT];
  logic [PW-1:0]   tp_id    [LAT];
  logic            tp_zero  [LAT];

  logic [4:0]      fifo_log2 [NREQ][2];
  logic            fifo_zf   [NREQ][2];
  logic            fifo_wp   [NREQ];
  logic            fifo_rp   [NREQ];

  logic [4:0]      push_log2;
  logic            push_zero;

  // Credit is whatever is not already in flight or sitting in the FIFO.
  always_comb begin
    eligible = '0;
    fifo_ne  = '0;
    for (int i = 0; i < NREQ; i++) begin
      credit[i]   = 2'd2 - inflight[i] - fifo_cnt[i];
      eligible[i] = req_valid[i] && (credit[i] != 2'd0);
      fifo_ne[i]  = (fifo_cnt[i] != 2'd0);
    end
  end

  // Round-robin pick: first eligible index at or after rr_ptr.
  always_comb begin : arb
    logic [PW-1:0] cand;
    cand    = '0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(rr_ptr) + k) % NREQ);
      if (!gnt_any && eligible[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  // One-hot grant and the granted operand.
  always_comb begin
    gnt_vec = '0;
    if (gnt_any) gnt_vec[gnt_id] = 1'b1;
    req_ready = reset ? '0 : gnt_vec;
    gnt_opnd  = req_v[32*gnt_id +: 32];
    gnt_zero  = (gnt_opnd == 32'd0);
  end

  // Result delivery: tag pipe output steers the core result into FIFO[id].
  always_comb begin
    push_vec  = '0;
    if (tp_valid[LAT-1]) push_vec[tp_id[LAT-1]] = 1'b1;
    push_zero = tp_zero[LAT-1];
    push_log2 = tp_zero[LAT-1] ? 5'd0 : core_log2;
    pop_vec   = fifo_ne & rsp_ready;
  end

  // Issue register: operand to the core, issue tag, round-robin pointer.
  // A zero operand leaves core_v untouched; the core output is ignored for it.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      core_v    <= '0;
      iss_valid <= 1'b0;
      iss_id    <= '0;
      iss_zero  <= 1'b0;
    end else begin
      iss_valid <= gnt_any;
      iss_id    <= gnt_id;
      iss_zero  <= gnt_zero;
      if (gnt_any && !gnt_zero) core_v <= gnt_opnd;
      if (gnt_any) rr_ptr <= (gnt_id == PW'(NREQ-1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Tag pipe tracking the core, LAT stages behind the issue register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < LAT; j++) begin
        tp_valid[j] <= 1'b0;
        tp_id[j]    <= '0;
        tp_zero[j]  <= 1'b0;
      end
    end else begin
      tp_valid[0] <= iss_valid;
      tp_id[0]    <= iss_id;
      tp_zero[0]  <= iss_zero;
      for (int j = 1; j < LAT; j++) begin
        tp_valid[j] <= tp_valid[j-1];
        tp_id[j]    <= tp_id[j-1];
        tp_zero[j]  <= tp_zero[j-1];
      end
    end
  end

  // Per-requester occupancy: in-flight grows on grant, FIFO on push.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (reset) begin
        inflight[i] <= 2'd0;
        fifo_cnt[i] <= 2'd0;
      end else begin
        inflight[i] <= inflight[i] + {1'b0, gnt_vec[i]} - {1'b0, push_vec[i]};
        fifo_cnt[i] <= fifo_cnt[i] + {1'b0, push_vec[i]} - {1'b0, pop_vec[i]};
      end
    end
  end

  // Two-entry result FIFOs; push and pop in one cycle both take effect.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (reset) begin
        fifo_wp[i]      <= 1'b0;
        fifo_rp[i]      <= 1'b0;
        fifo_log2[i][0] <= 5'd0;
        fifo_log2[i][1] <= 5'd0;
        fifo_zf[i][0]   <= 1'b0;
        fifo_zf[i][1]   <= 1'b0;
      end else begin
        if (push_vec[i]) begin
          fifo_log2[i][fifo_wp[i]] <= push_log2;
          fifo_zf[i][fifo_wp[i]]   <= push_zero;
          fifo_wp[i]               <= ~fifo_wp[i];
        end
        if (pop_vec[i]) fifo_rp[i] <= ~fifo_rp[i];
      end
    end
  end

  // Response outputs show the FIFO heads; all forced quiet during reset.
  always_comb begin
    rsp_valid = '0;
    rsp_log2  = '0;
    rsp_zero  = '0;
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i]       = !reset && fifo_ne[i];
      rsp_log2[5*i +: 5] = reset ? 5'd0 : fifo_log2[i][fifo_rp[i]];
      rsp_zero[i]        = !reset && fifo_zf[i][fifo_rp[i]];
    end
  end

  // Busy while anything is issued, in the tag pipe, or buffered.
  always_comb begin
    busy = iss_valid || (|fifo_ne);
    for (int j = 0; j < LAT; j++) busy = busy || tp_valid[j];
    if (reset) busy = 1'b0;
  end

endmodule

// File: tb/tb_ilog2_arb.sv
// Directed bench for ilog2_arb with a behavioural LAT-cycle ilog2 core and a
// per-requester response scoreboard.
module tb_ilog2_arb;
  localparam int NREQ = 4;
  localparam int LAT  = 3;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [32*NREQ-1:0]  req_v;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     rsp_valid;
  logic [5*NREQ-1:0]   rsp_log2;
  logic [NREQ-1:0]     rsp_zero;
  logic [NREQ-1:0]     rsp_ready;
  logic [31:0]         core_v;
  logic [4:0]          core_log2;
  logic                busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] cpipe [LAT];
  logic [5:0] expq [NREQ][$];

  ilog2_arb #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_v(req_v), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_log2(rsp_log2), .rsp_zero(rsp_zero),
    .rsp_ready(rsp_ready), .core_v(core_v), .core_log2(core_log2),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] ilog2(input logic [31:0] v);
    for (int b = 31; b >= 0; b--) if (v[b]) return 5'(b);
    return 5'd0;
  endfunction

  // Behavioural shared core: result appears LAT cycles after core_v is sampled.
  always @(posedge clk) begin
    cpipe[0] <= ilog2(core_v);
    for (int j = 1; j < LAT; j++) cpipe[j] <= cpipe[j-1];
  end
  assign core_log2 = cpipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: log expected result at each grant, compare at each pop.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREQ; i++) expq[i].delete();
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          chk($sformatf("rsp_expected[%0d]", i), 32'(expq[i].size() != 0), 32'd1);
          if (expq[i].size() != 0) begin
            logic [5:0] e;
            e = expq[i].pop_front();
            chk($sformatf("rsp_log2[%0d]", i), 32'(rsp_log2[5*i +: 5]), 32'(e[4:0]));
            chk($sformatf("rsp_zero[%0d]", i), 32'(rsp_zero[i]), 32'(e[5]));
          end
        end
        if (req_valid[i] && req_ready[i])
          expq[i].push_back({req_v[32*i +: 32] == 32'd0, ilog2(req_v[32*i +: 32])});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic done;
    int   left;
    done      = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
      cyc();
    end
    chk({tag, "_drain"}, 32'(done), 32'd1);
    left = 0;
    for (int i = 0; i < NREQ; i++) left += expq[i].size();
    chk({tag, "_leftover"}, 32'(left), 32'd0);
  endtask

  task automatic send(input int i, input logic [31:0] v);
    logic got;
    got = 1'b0;
    req_valid[i]       = 1'b1;
    req_v[32*i +: 32]  = v;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1'b1;
      cyc();
    end
    req_valid[i] = 1'b0;
    chk("send_grant", 32'(got), 32'd1);
  endtask

  initial begin
    logic [15:0] pat6;
    int n2, noth, nidle;
    int cnt [NREQ];

    reset     = 1'b1;
    req_valid = '0;
    req_v     = '0;
    rsp_ready = '0;
    cyc();
    cyc();

    // Reset values, with requests pending to prove gating.
    req_valid = '1;
    req_v     = {32'h5, 32'h6, 32'h7, 32'h8};
    rsp_ready = '1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_core_v", core_v, 32'd0);
    chk("rst_rsp_log2", 32'(rsp_log2), 32'd0);
    chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    cyc();

    // Single request: grant in first cycle after reset, response 5 cycles later.
    reset     = 1'b0;
    req_valid = 4'b0001;
    req_v     = {32'h0, 32'h0, 32'h0, 32'h0000_1000};
    @(negedge clk);
    chk("single_grant", 32'(req_ready), 32'b0001);
    cyc();
    req_valid = '0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("single_valid_c%0d", c), 32'(rsp_valid[0]), 32'(c == 5));
      if (c == 1) begin
        chk("single_core_v", core_v, 32'h0000_1000);
        chk("single_busy", 32'(busy), 32'd1);
      end
      if (c == 5) begin
        chk("single_log2", 32'(rsp_log2[4:0]), 32'd12);
        chk("single_zero", 32'(rsp_zero[0]), 32'd0);
      end
      cyc();
    end
    drain("single");

    // Round-robin with all requesters continuously active.
    do_reset();
    rsp_ready = '1;
    req_valid = '1;
    for (int c = 0; c < 12; c++) begin
      for (int i = 0; i < NREQ; i++)
        req_v[32*i +: 32] = (32'h1 << ((c*7 + i*5) % 32)) | 32'(c*3 + i);
      @(negedge clk);
      chk($sformatf("rr_grant_c%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
      cyc();
    end
    drain("rr");

    // Zero operand in the middle of a stream from requester 1.
    do_reset();
    rsp_ready = '1;
    send(1, 32'h8000_0000);
    send(1, 32'h0);
    @(negedge clk);
    chk("zero_core_v_hold", core_v, 32'h8000_0000);
    send(1, 32'h0000_0001);
    drain("zero");

    // Backpressure on requester 2 only.
    do_reset();
    rsp_ready = 4'b1011;
    req_valid = '1;
    n2 = 0; noth = 0; nidle = 0;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < NREQ; i++) req_v[32*i +: 32] = 32'(100 + c*4 + i);
      @(negedge clk);
      if (req_ready[2]) n2++;
      if ((req_ready & 4'b1011) != 4'b0) noth++;
      if (req_ready == 4'b0) nidle++;
      cyc();
    end
    chk("bp_grants_req2", 32'(n2), 32'd2);
    chk("bp_grants_others", 32'(noth), 32'd18);
    chk("bp_idle_cycles", 32'(nidle), 32'd0);
    rsp_ready = '1;
    req_valid = 4'b0100;
    @(negedge clk);
    chk("bp_blocked_at_pop", 32'(req_ready), 32'd0);
    cyc();
    @(negedge clk);
    chk("bp_resume", 32'(req_ready), 32'b0100);
    cyc();
    drain("bp");

    // Full FIFO and zero credit on requester 3, then pop and grant together.
    do_reset();
    rsp_ready = 4'b0111;
    req_valid = 4'b1000;
    pat6 = 16'b1000_0110_0000_0011;
    for (int c = 0; c < 16; c++) begin
      if (c == 8) rsp_ready = '1;
      req_v[96 +: 32] = 32'h10 << c;
      @(negedge clk);
      chk($sformatf("pp_grant_c%0d", c), 32'(req_ready[3]), 32'(pat6[c]));
      cyc();
    end
    drain("pp");

    // Reset mid-flight discards everything and restores full credit.
    do_reset();
    rsp_ready = '1;
    req_valid = '1;
    req_v     = {32'h11, 32'h222, 32'h3333, 32'h44444};
    cyc();
    cyc();
    cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    cyc();
    reset     = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("post_rst_valid_c%0d", c), 32'(rsp_valid), 32'd0);
      chk($sformatf("post_rst_busy_c%0d", c), 32'(busy), 32'd0);
      cyc();
    end
    rsp_ready = '0;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) cnt[i]++;
      cyc();
    end
    for (int i = 0; i < NREQ; i++)
      chk($sformatf("post_rst_credit[%0d]", i), 32'(cnt[i]), 32'd2);
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
